// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the combinational instruction
// memory and buffers {pc, instr} in a small FIFO toward IF/ID. Optional: FETCH_ALIGN_CHECK_EN.
module im_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2,
  parameter int          QAW      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] im_addr,
  input  logic [31:0] im_dout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_err
`endif
);

  localparam logic [QAW:0] FULL = (QAW+1)'(QDEPTH);

  logic [31:0]    fpc;
  logic [QAW-1:0] rd_ptr;
  logic [QAW-1:0] wr_ptr;
  logic [QAW:0]   count;
  logic [31:0]    q_pc    [QDEPTH];
  logic [31:0]    q_instr [QDEPTH];
  logic           pop;
  logic           push;
  logic           blocked;
  logic [31:0]    redirect_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;

  // A misaligned redirect poisons the fetch stream until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (redirect && (redirect_pc[1:0] != 2'b00))
      err_q <= 1'b1;
  end

  assign fetch_err    = err_q;
  assign blocked      = err_q;
  assign redirect_tgt = redirect_pc;
`else
  assign blocked      = 1'b0;
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign im_addr  = fpc;
  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? q_pc[rd_ptr]    : 32'h0;
  assign if_instr = if_valid ? q_instr[rd_ptr] : 32'h0;

  // A full queue still accepts a new word when the head leaves in the same cycle.
  assign pop  = if_valid & id_ready & ~redirect;
  assign push = fetch_en & ~redirect & ~blocked & ((count < FULL) | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc    <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      fpc    <= redirect_tgt;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        fpc    <= fpc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= fpc;
      q_instr[wr_ptr] <= im_dout;
    end
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Scoreboard bench for im_fetch_ctrl: expected pc stream queued at reset/redirect,
// popped and compared on every decode handshake.
module tb_im_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] im_addr;
  logic [31:0] im_dout;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_err;
`endif

  logic [31:0] mem [1024];
  logic [31:0] exp_q [$];
  int          n_vec;
  int          n_err;
  int          n_pop;

  im_fetch_ctrl #(.RESET_PC(RESET_PC), .QDEPTH(2), .QAW(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .im_addr    (im_addr),
    .im_dout    (im_dout),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_ready   (id_ready)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_err  (fetch_err)
`endif
  );

  assign im_dout = mem[im_addr[11:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i) * 32'd4);
  endtask

  // Decode side: every accepted head must be the next expected pc and its memory word.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_valid && id_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          chk("sb_underrun", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("sb_pc", if_pc, e);
          chk("sb_instr", if_instr, mem[e[11:2]]);
        end
        n_pop++;
      end else if (!if_valid) begin
        chk("empty_pc", if_pc, 32'h0);
        chk("empty_instr", if_instr, 32'h0);
      end
    end
  end

  initial begin
    int          p0;
    logic [31:0] a;
    n_vec = 0;
    n_err = 0;
    n_pop = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h9E37_79B1 + 32'h1357_0000;
    mem[0] = 32'h2008_0005;

    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    step(2);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_addr", im_addr, RESET_PC);

    // T1: first instruction one cycle after reset release, then streaming
    fetch_en = 1'b1; id_ready = 1'b1; rst = 1'b0; load_exp(RESET_PC);
    step(1);
    chk("t1_valid", 32'(if_valid), 32'd1);
    chk("t1_pc", if_pc, 32'h0);
    chk("t1_instr", if_instr, 32'h2008_0005);
    p0 = n_pop;
    step(3);
    chk("t1_pops", 32'(n_pop - p0), 32'd3);
    rst = 1'b1;
    #1;
    chk("t1_midrst_valid", 32'(if_valid), 32'd0);
    chk("t1_midrst_addr", im_addr, RESET_PC);
    exp_q.delete();

    // T2: backpressure holds exactly two entries
    id_ready = 1'b0;
    step(1);
    rst = 1'b0; load_exp(RESET_PC);
    step(2);
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", 32'(if_valid), 32'd1);
      chk("t2_addr", im_addr, 32'h8);
      chk("t2_pc", if_pc, 32'h0);
      chk("t2_instr", if_instr, 32'h2008_0005);
      step(1);
    end
    id_ready = 1'b1;
    p0 = n_pop;
    step(3);
    chk("t2_pops", 32'(n_pop - p0), 32'd3);

    // T3: redirect with a full queue discards the stale entries
    id_ready = 1'b0;
    step(2);
    redirect = 1'b1; redirect_pc = 32'h40; load_exp(32'h40);
    step(1);
    redirect = 1'b0;
    chk("t3_addr", im_addr, 32'h40);
    chk("t3_flush", 32'(if_valid), 32'd0);
    id_ready = 1'b1;
    step(1);
    chk("t3_valid", 32'(if_valid), 32'd1);
    chk("t3_pc", if_pc, 32'h40);
    chk("t3_instr", if_instr, mem[16]);

    // T4: full queue with steady pop keeps two entries in flight
    id_ready = 1'b0;
    step(2);
    id_ready = 1'b1;
    chk("t4_full", im_addr - if_pc, 32'h8);
    p0 = n_pop;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t4_depth", im_addr - if_pc, 32'h8);
    end
    chk("t4_pops", 32'(n_pop - p0), 32'd4);

    // T5: fetch disabled drains the queue while the fetch PC holds
    fetch_en = 1'b0;
    a = im_addr;
    p0 = n_pop;
    step(2);
    chk("t5_drained", 32'(if_valid), 32'd0);
    chk("t5_addr", im_addr, a);
    step(2);
    chk("t5_idle", 32'(if_valid), 32'd0);
    chk("t5_addr_held", im_addr, a);
    chk("t5_pops", 32'(n_pop - p0), 32'd2);
    fetch_en = 1'b1;
    step(1);
    chk("t5_resume_pc", if_pc, a);

    // Fetch PC wraps naturally past the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; load_exp(32'hFFFF_FFFC);
    step(1);
    redirect = 1'b0;
    p0 = n_pop;
    step(4);
    chk("wrap_pops", 32'(n_pop - p0), 32'd3);

    // T6: misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h42;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_q.delete();
    step(1);
    redirect = 1'b0;
    chk("t6_err", 32'(fetch_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t6_blocked", 32'(if_valid), 32'd0);
      chk("t6_err_sticky", 32'(fetch_err), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("t6_err_rst", 32'(fetch_err), 32'd0);
    step(1);
    rst = 1'b0; load_exp(RESET_PC);
    step(1);
    chk("t6_recover_pc", if_pc, RESET_PC);
`else
    load_exp(32'h40);
    step(1);
    redirect = 1'b0;
    chk("t6_addr", im_addr, 32'h40);
    step(1);
    chk("t6_valid", 32'(if_valid), 32'd1);
    chk("t6_pc", if_pc, 32'h40);
`endif
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
